// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic-array result path.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// Contents:
//   deskew_state_e  input-side tile tracking state of result_deskew
//   ROW_CNT_W       width of the popped-row counter
//   sat_inc         saturating increment for the row counter
package systolic_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } deskew_state_e;

  localparam int ROW_CNT_W = 16;

  // Counter holds at all-ones rather than wrapping back to zero.
  function automatic logic [ROW_CNT_W-1:0] sat_inc(input logic [ROW_CNT_W-1:0] v);
    return (v == {ROW_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/result_deskew_row_fifo.sv
// Purpose: synchronous row FIFO with a registered head entry.
// Latency: a push into an empty FIFO is visible at the head on the next cycle.
// Backpressure: none upstream; a push while full is accepted only if a pop happens in the same cycle.
//
// Ports:
//   clk, rst      clock, async active-high reset (pointers only; storage is not reset)
//   push_vld      write push_dat at the tail (ignored when full without a pop)
//   push_dat      WIDTH-bit entry to write
//   pop_vld       advance the head (ignored when empty)
//   head_dat      registered copy of the entry at the head
//   empty, full   occupancy flags, derived from pointers with one extra wrap bit
module row_fifo
  import systolic_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head_q;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_ptr_nxt;
  logic             do_pop;
  logic             do_push;

  // Same index with opposite wrap bits means the write side lapped the read side.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop_vld && !empty;
  assign do_push = push_vld && (!full || do_pop);

  assign rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Storage and head carry no reset; the head is only meaningful while !empty.
  // The head is reloaded every cycle from the slot the read pointer will point
  // at. If that slot is the one being written right now (empty FIFO, or one
  // entry popped while another is pushed) the incoming data bypasses memory.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    if (do_push && (wr_ptr == rd_ptr_nxt)) head_q <= push_dat;
    else                                   head_q <= mem[rd_ptr_nxt[AW-1:0]];
  end

  assign head_dat = head_q;

endmodule

// File: rtl/result_deskew.sv
// Purpose: remove the column skew from systolic-array results and buffer whole rows for writeback.
// Latency: valid_i at cycle t shows as valid_o at t+DATA_NUM when the FIFO was empty.
// Backpressure: ready_i stalls the drain only; the array side never stalls, a row arriving to a full FIFO is dropped and overflow_o latches.
//
// Ports:
//   clk, rst    clock, async active-high reset
//   data_in     skewed columns, lane j lags lane 0 by j cycles
//   valid_i     row valid, aligned to lane 0
//   done_i      last row of tile, aligned to lane 0, qualified by valid_i
//   data_out    aligned row at the FIFO head (don't-care while valid_o=0)
//   valid_o     FIFO holds at least one row
//   ready_i     consumer accepts the head row
//   last_o      head row closes its tile
//   done_o      one-cycle pulse after a tile's last row is popped
//   overflow_o  sticky: an aligned row was dropped
//   row_cnt_o   rows popped so far in the current tile (saturating)
module result_deskew
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_NUM   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_NUM-1:0][DATA_WIDTH-1:0]  data_in,
  input  logic                                 valid_i,
  input  logic                                 done_i,
  output logic [DATA_NUM-1:0][DATA_WIDTH-1:0]  data_out,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic                                 last_o,
  output logic                                 done_o,
  output logic                                 overflow_o,
  output logic [ROW_CNT_W-1:0]                 row_cnt_o
);

  localparam int ROW_W = DATA_WIDTH * DATA_NUM;
  localparam int ENT_W = ROW_W + 1;

  logic [DATA_NUM-1:0][DATA_WIDTH-1:0] row_dat;
  logic                                row_vld;
  logic                                row_done;

  // ---------------------------------------------------------------------------
  // Per-lane data delay: lane j waits DATA_NUM-1-j cycles so every lane of a
  // row lines up with the last lane, which is passed straight through.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < DATA_NUM; j++) begin : g_lane
    localparam int D = DATA_NUM - 1 - j;
    if (D == 0) begin : g_pass
      assign row_dat[j] = data_in[j];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sr [D];
      always_ff @(posedge clk) begin
        sr[0] <= data_in[j];
        for (int k = 1; k < D; k++) begin
          sr[k] <= sr[k-1];
        end
      end
      assign row_dat[j] = sr[D-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Control delay: valid/done ride alongside lane 0 for DATA_NUM-1 cycles.
  // These registers are reset so that data still travelling through the array
  // after a reset never turns into a row.
  // ---------------------------------------------------------------------------
  if (DATA_NUM == 1) begin : g_ctl_pass
    assign row_vld  = valid_i;
    assign row_done = valid_i && done_i;
  end else begin : g_ctl_dly
    logic [DATA_NUM-2:0] vld_sr;
    logic [DATA_NUM-2:0] done_sr;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_sr  <= '0;
        done_sr <= '0;
      end else begin
        vld_sr[0]  <= valid_i;
        done_sr[0] <= valid_i && done_i;
        for (int k = 1; k < DATA_NUM - 1; k++) begin
          vld_sr[k]  <= vld_sr[k-1];
          done_sr[k] <= done_sr[k-1];
        end
      end
    end
    assign row_vld  = vld_sr[DATA_NUM-2];
    assign row_done = done_sr[DATA_NUM-2];
  end

  // ---------------------------------------------------------------------------
  // Row FIFO: each entry is {last, row}; tile boundaries travel only here.
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] head_dat;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             drop;

  row_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (row_vld),
    .push_dat ({row_done, row_dat}),
    .pop_vld  (pop),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign valid_o  = !fifo_empty;
  assign pop      = valid_o && ready_i;
  assign data_out = head_dat[ROW_W-1:0];
  assign last_o   = valid_o && head_dat[ENT_W-1];

  // A same-cycle pop frees the slot, so only a push into a full, unpopped FIFO is lost.
  assign drop = row_vld && fifo_full && !pop;

  // ---------------------------------------------------------------------------
  // Input-side tile tracking. Dropped rows still move the state so the tile
  // framing seen upstream stays consistent with what the array produced.
  // ---------------------------------------------------------------------------
  deskew_state_e state_q;
  deskew_state_e state_d;
  logic          in_tile;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (row_vld && !row_done) state_d = COLLECT;
      COLLECT: if (row_vld && row_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_tile = (state_q == COLLECT);
  end

  // Tile-open status has no port; it stays in the netlist for debug probing.
  logic unused_in_tile;
  assign unused_in_tile = in_tile;

  // ---------------------------------------------------------------------------
  // Drain-side bookkeeping: sticky overflow, per-tile row count, done pulse.
  // ---------------------------------------------------------------------------
  logic                 overflow_q;
  logic                 done_q;
  logic [ROW_CNT_W-1:0] row_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      row_cnt_q  <= '0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      done_q <= pop && head_dat[ENT_W-1];
      if (pop) begin
        if (head_dat[ENT_W-1]) row_cnt_q <= '0;
        else                   row_cnt_q <= sat_inc(row_cnt_q);
      end
    end
  end

  assign overflow_o = overflow_q;
  assign done_o     = done_q;
  assign row_cnt_o  = row_cnt_q;

endmodule

// File: tb/tb_result_deskew.sv
module tb_result_deskew;
  import systolic_pkg::*;

  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---- main DUT (DATA_NUM=4) ----
  logic                 rst;
  logic [N-1:0][DW-1:0] data_in;
  logic [N-1:0][DW-1:0] data_out;
  logic                 valid_i, done_i, ready_i;
  logic                 valid_o, last_o, done_o, overflow_o;
  logic [15:0]          row_cnt_o;

  result_deskew #(.DATA_WIDTH(DW), .DATA_NUM(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_i(valid_i), .done_i(done_i),
    .data_out(data_out), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
    .done_o(done_o), .overflow_o(overflow_o), .row_cnt_o(row_cnt_o)
  );

  // ---- single-lane DUT (DATA_NUM=1) ----
  logic                 rst1;
  logic [0:0][DW-1:0]   d1_in;
  logic [0:0][DW-1:0]   d1_out;
  logic                 d1_vld, d1_done, d1_rdy;
  logic                 d1_vo, d1_last, d1_dn, d1_ovf;
  logic [15:0]          d1_cnt;

  result_deskew #(.DATA_WIDTH(DW), .DATA_NUM(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst1), .data_in(d1_in), .valid_i(d1_vld), .done_i(d1_done),
    .data_out(d1_out), .valid_o(d1_vo), .ready_i(d1_rdy), .last_o(d1_last),
    .done_o(d1_dn), .overflow_o(d1_ovf), .row_cnt_o(d1_cnt)
  );

  // ---- bookkeeping ----
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- reference model: rows as a queue, arrival scheduled N-1 cycles after entry ----
  typedef struct { logic [31:0] row; logic last; } ent_t;
  typedef struct { int due; logic [31:0] row; logic last; } pend_t;

  ent_t        mq[$];
  pend_t       pq[$];
  logic [15:0] m_cnt;
  logic        m_done;
  logic        m_ovf;
  int          cyc;
  logic [31:0] hist [N];   // hist[k] = row presented at lane 0 k cycles ago
  int          n_pop, n_done, n_lastpop;

  task automatic model_clear();
    mq.delete();
    pq.delete();
    m_cnt  = '0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Drive one cycle of array output: lane j carries the row that entered j cycles ago.
  task automatic apply(input logic vld, input logic dn, input logic [31:0] row, input logic rdy);
    for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = vld ? row : $urandom;
    for (int j = 0; j < N; j++) data_in[j] = hist[j][DW*j +: DW];
    valid_i = vld;
    done_i  = dn;
    ready_i = rdy;
    if (vld) pq.push_back('{due: cyc + N - 1, row: row, last: dn});
  endtask

  task automatic model_check();
    logic mv;
    mv = (mq.size() > 0);
    chk("valid_o", 32'(valid_o), 32'(mv));
    if (mv) begin
      chk("last_o", 32'(last_o), 32'(mq[0].last));
      chk("data_out", 32'(data_out), mq[0].row);
    end else begin
      chk("last_o", 32'(last_o), 32'd0);
    end
    chk("done_o", 32'(done_o), 32'(m_done));
    chk("row_cnt_o", 32'(row_cnt_o), 32'(m_cnt));
    chk("overflow_o", 32'(overflow_o), 32'(m_ovf));
  endtask

  // Clock edge at the end of the current cycle: pop first, then the arriving row.
  task automatic model_edge();
    logic p;
    p = (mq.size() > 0) && ready_i;
    if (p) n_pop++;
    if (p && mq[0].last) n_lastpop++;
    m_done = 1'b0;
    if (p) begin
      if (mq[0].last) begin
        m_cnt  = '0;
        m_done = 1'b1;
      end else if (m_cnt != 16'hFFFF) begin
        m_cnt = m_cnt + 16'd1;
      end
      void'(mq.pop_front());
    end
    while (pq.size() > 0 && pq[0].due == cyc) begin
      if (mq.size() < DEPTH) mq.push_back('{row: pq[0].row, last: pq[0].last});
      else                   m_ovf = 1'b1;
      void'(pq.pop_front());
    end
    cyc++;
  endtask

  task automatic step(input logic vld, input logic dn, input logic [31:0] row, input logic rdy);
    apply(vld, dn, row, rdy);
    #1;
    if (done_o) n_done++;
    model_check();
    model_edge();
    @(negedge clk);
  endtask

  // Reset is raised between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst     = 1'b1;
    valid_i = 1'b0;
    done_i  = 1'b0;
    ready_i = 1'b0;
    #1;
    chk("rst.valid_o", 32'(valid_o), 32'd0);
    chk("rst.done_o", 32'(done_o), 32'd0);
    chk("rst.last_o", 32'(last_o), 32'd0);
    chk("rst.overflow_o", 32'(overflow_o), 32'd0);
    chk("rst.row_cnt_o", 32'(row_cnt_o), 32'd0);
    chk("rst.state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    n_pop = 0; n_done = 0; n_lastpop = 0;
  endtask

  // ---- directed vectors: one record per cycle, ready_i held high ----
  typedef struct {
    logic        vld, dn;
    logic [31:0] row;
    logic        e_vld, e_last, e_done;
    logic [31:0] e_dat;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic dn, input logic [31:0] row,
                              input logic ev, input logic el, input logic ed,
                              input logic [31:0] edat, input logic [15:0] ecnt);
    vec_t v;
    v.vld = vld; v.dn = dn; v.row = row;
    v.e_vld = ev; v.e_last = el; v.e_done = ed; v.e_dat = edat; v.e_cnt = ecnt;
    return v;
  endfunction

  localparam int NT = 15;
  vec_t tbl [NT];

  initial begin
    logic [31:0] ra, rb1, rb2, rb3;
    ra  = 32'h13121110;   // lane0=10 .. lane3=13
    rb1 = 32'h23222120;
    rb2 = 32'h33323130;
    rb3 = 32'h43424140;
    // single row tile, then a 3-row tile
    tbl[0]  = mk(1, 1, ra,  0, 0, 0, 0,   0);
    tbl[1]  = mk(0, 0, 0,   0, 0, 0, 0,   0);
    tbl[2]  = mk(0, 0, 0,   0, 0, 0, 0,   0);
    tbl[3]  = mk(0, 0, 0,   0, 0, 0, 0,   0);
    tbl[4]  = mk(0, 0, 0,   1, 1, 0, ra,  0);
    tbl[5]  = mk(0, 0, 0,   0, 0, 1, 0,   0);
    tbl[6]  = mk(1, 0, rb1, 0, 0, 0, 0,   0);
    tbl[7]  = mk(1, 0, rb2, 0, 0, 0, 0,   0);
    tbl[8]  = mk(1, 1, rb3, 0, 0, 0, 0,   0);
    tbl[9]  = mk(0, 0, 0,   0, 0, 0, 0,   0);
    tbl[10] = mk(0, 0, 0,   1, 0, 0, rb1, 0);
    tbl[11] = mk(0, 0, 0,   1, 0, 0, rb2, 1);
    tbl[12] = mk(0, 0, 0,   1, 1, 0, rb3, 2);
    tbl[13] = mk(0, 0, 0,   0, 0, 1, 0,   0);
    tbl[14] = mk(0, 0, 0,   0, 0, 0, 0,   0);

    rst = 1'b1; rst1 = 1'b1;
    valid_i = 0; done_i = 0; ready_i = 0; data_in = '0;
    d1_vld = 0; d1_done = 0; d1_rdy = 0; d1_in = '0;
    cyc = 0;
    for (int k = 0; k < N; k++) hist[k] = $urandom;
    model_clear();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < NT; i++) begin
      apply(tbl[i].vld, tbl[i].dn, tbl[i].row, 1'b1);
      #1;
      chk("tbl.valid_o", 32'(valid_o), 32'(tbl[i].e_vld));
      chk("tbl.last_o", 32'(last_o), 32'(tbl[i].e_last));
      if (tbl[i].e_vld) chk("tbl.data_out", 32'(data_out), tbl[i].e_dat);
      chk("tbl.done_o", 32'(done_o), 32'(tbl[i].e_done));
      chk("tbl.row_cnt_o", 32'(row_cnt_o), 32'(tbl[i].e_cnt));
      chk("tbl.overflow_o", 32'(overflow_o), 32'd0);
      model_edge();
      @(negedge clk);
    end

    // overrun: 6 rows with no drain, 4 kept, 2 dropped
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, $urandom, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("ovr.overflow_o", 32'(overflow_o), 32'd1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    chk("ovr.drained", 32'(n_pop), 32'd4);
    chk("ovr.sticky", 32'(overflow_o), 32'd1);

    // full FIFO with a pop on the same edge as a push: nothing lost
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, $urandom, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    chk("full_pop.drained", 32'(n_pop), 32'd5);
    chk("full_pop.overflow_o", 32'(overflow_o), 32'd0);

    // two 2-row tiles back to back
    do_reset();
    step(1, 0, 32'hA1A1A1A1, 1);
    step(1, 1, 32'hA2A2A2A2, 1);
    step(1, 0, 32'hB1B1B1B1, 1);
    step(1, 1, 32'hB2B2B2B2, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    chk("b2b.done_pulses", 32'(n_done), 32'd2);
    chk("b2b.last_pops", 32'(n_lastpop), 32'd2);

    // reset in the middle of a tile with 2 rows buffered
    do_reset();
    step(1, 0, $urandom, 0);
    step(1, 0, $urandom, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("midrst.state_before", 32'(dut.state_q), 32'(COLLECT));
    chk("midrst.valid_before", 32'(valid_o), 32'd1);
    do_reset();
    step(1, 1, 32'h5A6B7C8D, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    chk("midrst.fresh_pops", 32'(n_pop), 32'd1);
    chk("midrst.fresh_done", 32'(n_done), 32'd1);

    // randomized traffic with varying drain rates
    for (int b = 0; b < 3; b++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        logic v, d, r;
        v = ($urandom_range(0, 9) < 6);
        d = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 9) < (b == 0 ? 8 : (b == 1 ? 3 : 5)));
        step(v, d, $urandom, r);
      end
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    end

    // single-lane instance: 2 rows buffered, reset, then latency 1
    rst1 = 1'b0;
    @(negedge clk);
    d1_vld = 1; d1_done = 0; d1_in[0] = 8'hA1; d1_rdy = 0;
    @(negedge clk);
    d1_in[0] = 8'hA2;
    @(negedge clk);
    d1_vld = 0;
    #1;
    chk("n1.valid_before", 32'(d1_vo), 32'd1);
    chk("n1.state_before", 32'(dut1.state_q), 32'(COLLECT));
    rst1 = 1'b1;
    #1;
    chk("n1.rst.valid_o", 32'(d1_vo), 32'd0);
    chk("n1.rst.done_o", 32'(d1_dn), 32'd0);
    chk("n1.rst.state", 32'(dut1.state_q), 32'(IDLE));
    @(negedge clk);
    rst1 = 1'b0;
    d1_vld = 1; d1_done = 1; d1_in[0] = 8'h5A; d1_rdy = 1;
    #1;
    chk("n1.valid_t0", 32'(d1_vo), 32'd0);
    @(negedge clk);
    d1_vld = 0; d1_done = 0; d1_in[0] = 8'hFF;
    #1;
    chk("n1.valid_t1", 32'(d1_vo), 32'd1);
    chk("n1.data_t1", 32'(d1_out), 32'h5A);
    chk("n1.last_t1", 32'(d1_last), 32'd1);
    chk("n1.cnt_t1", 32'(d1_cnt), 32'd0);
    @(negedge clk);
    #1;
    chk("n1.done_t2", 32'(d1_dn), 32'd1);
    chk("n1.valid_t2", 32'(d1_vo), 32'd0);
    chk("n1.cnt_t2", 32'(d1_cnt), 32'd0);
    chk("n1.overflow", 32'(d1_ovf), 32'd0);
    @(negedge clk);
    #1;
    chk("n1.done_t3", 32'(d1_dn), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
